seg7_bcd_counter_mux: RTL and testbench

- Multi-digit decimal (BCD) up/down counter with a built-in tick prescaler and a time-multiplexed 7-segment display driver.
- Successor to the single-digit free-running segment counter. Adds:
  - parametrised digit count
  - enable, direction and synchronous clear
  - carry/borrow between digits
  - digit scanning
- Sits at board top level; drives the shared segment bus and the per-digit enables directly.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_bcd_counter_mux_bcd_digit.sv | 34 +++
 rtl/seg7_bcd_counter_mux.sv | 162 ++++++++++++++++
 tb/tb_seg7_bcd_counter_mux.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment encoding for the BCD counter / display multiplexer.
// Segments are active-low, bit6 = a ... bit0 = g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    // Non-decimal nibbles never come out of the counter; show them blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_bcd_counter_mux_bcd_digit.sv
// One decimal digit of the up/down counter. carry is combinational so a
// chain of digits ripples a single step through in the same cycle; it means
// "carry" when counting up and "borrow" when counting down.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up_dn,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    // This digit passes the step on when it is about to roll past its limit.
    assign carry = step && (up_dn ? (value == 4'd9) : (value == 4'd0));

    // Digit register: clear wins, otherwise step up or down with 9<->0 roll.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 4'd0;
        end else if (clr) begin
            value <= 4'd0;
        end else if (step) begin
            if (up_dn) begin
                value <= (value == 4'd9) ? 4'd0 : value + 4'd1;
            end else begin
                value <= (value == 4'd0) ? 4'd9 : value - 4'd1;
            end
        end
    end

endmodule

// File: rtl/seg7_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with tick prescaler and a time-multiplexed
// 7-segment driver. Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks
// leading zero digits (digit 0 is always shown).
// There is no handshake on this block: en/up_dn/clr are level inputs sampled
// every rising edge, and outputs are plain registered levels/pulses.
module seg7_bcd_counter_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    output logic [6:0]            led_7seg,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]     presc;
    logic              tick;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] carry;

    logic [SW-1:0]     scan_cnt;
    logic [IW-1:0]     scan_idx;
    logic [3:0]        cur_digit;
    logic              cur_blank;
    logic [6:0]        next_seg;
    logic [DIGITS-1:0] next_sel;

    // ------------------------------------------------------------------
    // Prescaler: one tick every TICK_DIV enabled cycles; frozen while en=0.
    // ------------------------------------------------------------------
    assign tick = en && (presc == PRESC_LAST);

    // Prescaler register; clr restarts the tick period from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Digit chain: tick steps digit 0, each carry steps the next digit.
    // ------------------------------------------------------------------
    assign step[0] = tick;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k > 0) begin : g_link
            assign step[k] = carry[k-1];
        end
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .step  (step[k]),
            .up_dn (up_dn),
            .clr   (clr),
            .value (count_bcd[4*k +: 4]),
            .carry (carry[k])
        );
    end

    // wrap pulses in the same cycle the count shows the rolled value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
        end else if (clr) begin
            wrap <= 1'b0;
        end else begin
            wrap <= carry[DIGITS-1];
        end
    end

    // ------------------------------------------------------------------
    // Scan: free-running divider advancing the displayed digit index.
    // ------------------------------------------------------------------
    // Scan divider and index; deliberately ignores en and clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Select the digit under the scan index and build its one-cold enable.
    always_comb begin
        cur_digit = 4'd0;
        next_sel  = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == int'(scan_idx)) begin
                cur_digit   = count_bcd[4*k +: 4];
                next_sel[k] = 1'b0;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] upper_zero;

    // upper_zero[k]: digit k and every more-significant digit are zero.
    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc           = acc && (count_bcd[4*k +: 4] == 4'd0);
            upper_zero[k] = acc;
        end
    end

    // Blank a leading zero, but never the least significant digit.
    always_comb begin
        cur_blank = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (k == int'(scan_idx)) begin
                cur_blank = upper_zero[k];
            end
        end
    end
`else
    // Leading zeros are always displayed.
    always_comb begin
        cur_blank = 1'b0;
    end
`endif

    assign next_seg = cur_blank ? SEG_BLANK : bcd_to_seg(cur_digit);

    // Segments and select registered together so they never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_7seg  <= SEG_BLANK;
            digit_sel <= '1;
        end else begin
            led_7seg  <= next_seg;
            digit_sel <= next_sel;
        end
    end

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// Self-checking bench for seg7_bcd_counter_mux (DIGITS=2, TICK_DIV=4,
// SCAN_DIV=2). Honours SEG7_LEADING_ZERO_BLANK_EN when defined.
module tb_seg7_bcd_counter_mux;

    localparam int D    = 2;
    localparam int TD   = 4;
    localparam int SD   = 2;
    localparam int MAXC = 100;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           up_dn;
    logic           clr;
    logic [6:0]     led_7seg;
    logic [D-1:0]   digit_sel;
    logic [4*D-1:0] count_bcd;
    logic           wrap;

    int checks   = 0;
    int failures = 0;

    // reference model state: whole-number count, plain counters
    int         m_count, m_presc, m_wrap, m_scnt, m_idx;
    logic [6:0] m_led;
    logic [D-1:0] m_sel;

    seg7_bcd_counter_mux #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .clr       (clr),
        .led_7seg  (led_7seg),
        .digit_sel (digit_sel),
        .count_bcd (count_bcd),
        .wrap      (wrap)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_code(int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int cnt, int idx);
        int upper;
        upper = cnt / (10 ** idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx > 0 && upper == 0) return 7'b1111111;
`endif
        return seg_code(upper % 10);
    endfunction

    function automatic logic [4*D-1:0] to_bcd(int cnt);
        logic [4*D-1:0] r;
        int v;
        v = cnt;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_count = 0; m_presc = 0; m_wrap = 0; m_scnt = 0; m_idx = 0;
        m_led = 7'b1111111; m_sel = '1;
    endtask

    // model of one rising edge, using the inputs applied before it
    task automatic model_edge();
        logic tick;
        if (rst) begin
            model_reset();
        end else begin
            m_led = exp_seg(m_count, m_idx);
            m_sel = '1;
            m_sel[m_idx] = 1'b0;
            if (m_scnt == SD - 1) begin
                m_scnt = 0;
                m_idx  = (m_idx + 1) % D;
            end else begin
                m_scnt++;
            end
            tick = en && (m_presc == TD - 1);
            if (clr) begin
                m_count = 0; m_presc = 0; m_wrap = 0;
            end else begin
                m_wrap = 0;
                if (en) m_presc = tick ? 0 : m_presc + 1;
                if (tick) begin
                    if (up_dn) begin
                        m_wrap  = (m_count == MAXC - 1);
                        m_count = (m_count + 1) % MAXC;
                    end else begin
                        m_wrap  = (m_count == 0);
                        m_count = (m_count + MAXC - 1) % MAXC;
                    end
                end
            end
        end
    endtask

    // advance one clock; outputs are stable 1 time unit after the edge
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // count up from current value (en=1, up) until the model reaches target
    task automatic run_to(int target);
        en = 1'b1; up_dn = 1'b1; clr = 1'b0;
        for (int i = 0; i < 1000 && m_count != target; i++) cycle();
    endtask

    task automatic do_clear();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0;
        model_reset();
        repeat (3) cycle();
        checks++;
        if (count_bcd !== 8'h00 || led_7seg !== 7'b1111111 || digit_sel !== 2'b11 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: count=%h led=%b sel=%b wrap=%b, want 00 1111111 11 0", count_bcd, led_7seg, digit_sel, wrap);
        end
        rst = 1'b0;
        run_to(13);
        repeat (2) cycle();
        // asynchronous reset mid-count, checked before any further edge
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (count_bcd !== 8'h00 || led_7seg !== 7'b1111111 || digit_sel !== 2'b11 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: count=%h led=%b sel=%b wrap=%b, want 00 1111111 11 0", count_bcd, led_7seg, digit_sel, wrap);
        end
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_up_count();
        int wraps;
        logic [4*D-1:0] prev;
        wraps = 0;
        en = 1'b1; up_dn = 1'b1;
        prev = count_bcd;
        for (int i = 0; i < 420; i++) begin
            cycle();
            checks++;
            if (count_bcd !== to_bcd(m_count) || wrap !== m_wrap[0]) begin
                failures++;
                $display("FAIL up_count: count=%h wrap=%b, want %h %0d", count_bcd, wrap, to_bcd(m_count), m_wrap);
            end
            if (wrap === 1'b1) begin
                wraps++;
                checks++;
                if (prev !== 8'h99 || count_bcd !== 8'h00) begin
                    failures++;
                    $display("FAIL up_wrap: went %h -> %h, want 99 -> 00", prev, count_bcd);
                end
            end
            prev = count_bcd;
        end
        checks++;
        if (wraps != 1) begin
            failures++;
            $display("FAIL up_wrap_count: saw %0d wrap pulses, want 1", wraps);
        end
    endtask

    task automatic test_down_count();
        int changes;
        int wraps;
        logic [4*D-1:0] prev;
        do_clear();
        run_to(10);
        up_dn = 1'b0;
        changes = 0; wraps = 0;
        prev = count_bcd;
        for (int i = 0; i < 60; i++) begin
            cycle();
            checks++;
            if (count_bcd !== to_bcd(m_count) || wrap !== m_wrap[0]) begin
                failures++;
                $display("FAIL down_count: count=%h wrap=%b, want %h %0d", count_bcd, wrap, to_bcd(m_count), m_wrap);
            end
            if (count_bcd !== prev) begin
                changes++;
                if (changes == 1) begin
                    checks++;
                    if (prev !== 8'h10 || count_bcd !== 8'h09) begin
                        failures++;
                        $display("FAIL down_borrow: went %h -> %h, want 10 -> 09", prev, count_bcd);
                    end
                end
            end
            if (wrap === 1'b1) begin
                wraps++;
                checks++;
                if (prev !== 8'h00 || count_bcd !== 8'h99) begin
                    failures++;
                    $display("FAIL down_wrap: went %h -> %h, want 00 -> 99", prev, count_bcd);
                end
            end
            prev = count_bcd;
        end
        checks++;
        if (wraps != 1) begin
            failures++;
            $display("FAIL down_wrap_count: saw %0d wrap pulses, want 1", wraps);
        end
    endtask

    task automatic test_en_gating();
        logic [4*D-1:0] held;
        en = 1'b1; up_dn = 1'b1;
        repeat (2) cycle();
        en = 1'b0;
        held = count_bcd;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (count_bcd !== held || wrap !== 1'b0) begin
                failures++;
                $display("FAIL en_hold: count=%h wrap=%b, want %h 0", count_bcd, wrap, held);
            end
        end
        // tick timing after re-enable proves the prescaler was held
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (count_bcd !== to_bcd(m_count)) begin
                failures++;
                $display("FAIL en_resume: count=%h, want %h", count_bcd, to_bcd(m_count));
            end
        end
    endtask

    task automatic test_clr();
        do_clear();
        run_to(37);
        for (int i = 0; i < TD && m_presc != TD - 1; i++) cycle();
        clr = 1'b1;   // coincides with a tick
        cycle();
        checks++;
        if (count_bcd !== 8'h00 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL clr_tick: count=%h wrap=%b, want 00 0", count_bcd, wrap);
        end
        clr = 1'b0;
        for (int i = 1; i <= TD; i++) begin
            cycle();
            checks++;
            if (count_bcd !== ((i == TD) ? 8'h01 : 8'h00)) begin
                failures++;
                $display("FAIL clr_restart: cycle %0d count=%h, want %h", i, count_bcd, (i == TD) ? 8'h01 : 8'h00);
            end
        end
    endtask

    task automatic test_scan();
        do_clear();
        run_to(42);
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if (digit_sel === 2'b10 ? led_7seg !== 7'b0010010 :
                digit_sel === 2'b01 ? led_7seg !== 7'b1001100 : 1'b1) begin
                failures++;
                $display("FAIL scan_pair: sel=%b led=%b, want 10/0010010 or 01/1001100", digit_sel, led_7seg);
            end
            checks++;
            if (digit_sel !== m_sel || led_7seg !== m_led) begin
                failures++;
                $display("FAIL scan_model: sel=%b led=%b, want %b %b", digit_sel, led_7seg, m_sel, m_led);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] want_hi;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        want_hi = 7'b1111111;
`else
        want_hi = 7'b0000001;
`endif
        do_clear();
        run_to(7);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks++;
            if (digit_sel === 2'b01 ? led_7seg !== want_hi :
                digit_sel === 2'b10 ? led_7seg !== 7'b0001111 : 1'b1) begin
                failures++;
                $display("FAIL leading_zero: sel=%b led=%b, want hi %b lo 0001111", digit_sel, led_7seg, want_hi);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst   = 1'b0;
            en    = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
            end
            cycle();
            checks++;
            if (count_bcd !== to_bcd(m_count) || wrap !== m_wrap[0] ||
                led_7seg !== m_led || digit_sel !== m_sel) begin
                failures++;
                $display("FAIL random: cyc %0d count=%h wrap=%b led=%b sel=%b, want %h %0d %b %b",
                         i, count_bcd, wrap, led_7seg, digit_sel, to_bcd(m_count), m_wrap, m_led, m_sel);
            end
        end
        rst = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_count();
        test_en_gating();
        test_clr();
        test_scan();
        test_leading_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
